uart_cmd_responder: RTL and testbench
=====================================

// Module: uart_cmd_responder
// PURPOSE
//  Byte-level command responder between uart_receiver and uart_transmitter.
//  Parses host requests from the RX byte stream, reads/writes a small register file, and returns a response byte via the TX handshake.
//  Replaces the fixed echo/+1 loopback in top; register 0 drives the LEDs.
// PARAMETERS
//  NUM_REGS        8      register count; power of 2, 2..256; address = low log2(NUM_REGS) bits
//  TIMEOUT_CYCLES  12000  max clk cycles between bytes of one command (1 ms @ 12 MHz); >=2
// PORTS
//  clk        in   1  system clock (12 MHz)
//  rst        in   1  synchronous reset, active-high
//  rx_data    in   8  received byte; valid only while rx_valid=1
//  rx_valid   in   1  one-cycle strobe per received byte (RxD_data_ready)
//  tx_busy    in   1  transmitter busy (TxD_busy)
//  tx_data    out  8  response byte; stable from tx_start until tx_busy falls
//  tx_start   out  1  one-cycle request to transmitter (TxD_start)
//  reg0       out  8  register 0 contents (LED/GPIO)
//  overrun    out  1  sticky: a byte arrived while a response was pending
// BEHAVIOUR
//  Reset: state=IDLE, all regs=0x00, tx_data=0x00, tx_start=0, overrun=0, timeout counter=0.
//  Protocol (ASCII command bytes):
//   'W'(0x57) addr data -> regs[addr]<=data, respond 'K'(0x4B)
//   'R'(0x52) addr      -> respond regs[addr]
//   other first byte    -> respond '?'(0x3F), return to IDLE
//   addr >= NUM_REGS (upper bits nonzero) -> no write, respond '?'; for 'W' error issued after data byte consumed
//  FSM states: IDLE, GET_ADDR, GET_DATA, SEND, WAIT_ACK.
//   IDLE:     rx_valid -> latch cmd; 'W'/'R' -> GET_ADDR, else tx_data='?' -> SEND.
//   GET_ADDR: rx_valid -> latch addr; 'W' -> GET_DATA; 'R' -> tx_data=regs[addr] or '?' -> SEND.
//   GET_DATA: rx_valid -> write (if addr ok), tx_data='K' or '?' -> SEND.
//   SEND:     when tx_busy=0 drive tx_start=1 for exactly one cycle -> WAIT_ACK.
//   WAIT_ACK: when tx_busy=1 -> IDLE. If tx_busy not seen within 4 cycles -> IDLE anyway.
//  tx_start and tx_data are registered. Final byte rx_valid in cycle N, tx_busy=0 -> tx_start=1 in cycle N+1.
//  If tx_busy=1 on entering SEND, tx_start is held off; it pulses in the first cycle after tx_busy is seen low.
//  Register write takes effect the cycle after the data byte's rx_valid; reg0 reflects it then.
//  A read of an address written by the immediately preceding 'W' returns the new value.
//  Timeout: counter cleared on every rx_valid and in IDLE/SEND/WAIT_ACK.
//   In GET_ADDR/GET_DATA, counter reaching TIMEOUT_CYCLES -> IDLE. No response, no write.
//  rx_valid during SEND or WAIT_ACK: byte dropped, overrun<=1 (cleared only by rst).
//  rx_valid and timeout expiry in the same cycle: the byte wins and the counter resets.
//  rst mid-command or mid-SEND: immediate return to reset values.
//   tx_start is never asserted in the cycle rst is high.
//   A transmitter already started is not aborted.
// TESTING
//  'W',0x03,0xA5 then 'R',0x03 -> tx bytes 0x4B then 0xA5; regs[3]=0xA5.
//  'W',0x00,0x5C -> reg0=0x5C the cycle after the data strobe; response 0x4B.
//  'X' -> single 0x3F; 'R',0x09 (NUM_REGS=8) -> 0x3F; 'W',0x10,0x11 -> 0x3F, no register changes.
//  'W',0x01 then idle TIMEOUT_CYCLES+1 cycles then 'R',0x01 -> exactly one response 0x00, no write.
//  tx_busy held high 50 cycles when response ready -> tx_start pulses once, first cycle after tx_busy=0.
//  byte during WAIT_ACK -> overrun=1, byte ignored. rst mid-GET_DATA -> IDLE, regs=0, overrun=0, no tx_start.

Source files
------------

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_responder
// Description : Byte-level command responder between a UART receiver and a
//               UART transmitter. It parses 'W' addr data and 'R' addr
//               requests, accesses a small register file, and returns one
//               response byte per command through the TX handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_responder #(
    parameter int NUM_REGS       = 8,
    parameter int TIMEOUT_CYCLES = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [7:0] reg0,
    output logic       overrun
);

    localparam int              c_AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int              c_TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TLIM     = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      c_ACK_LAST = 2'd3;

    localparam logic [7:0] c_CMD_W  = 8'h57;
    localparam logic [7:0] c_CMD_R  = 8'h52;
    localparam logic [7:0] c_RSP_OK = 8'h4B;
    localparam logic [7:0] c_RSP_ER = 8'h3F;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;

    logic [2:0]      r_state;
    logic            r_isWrite;
    logic [7:0]      r_addr;
    logic [7:0]      r_regs [NUM_REGS];
    logic [7:0]      r_txData;
    logic            r_txStart;
    logic            r_overrun;
    logic [c_TW-1:0] r_timer;
    logic [1:0]      r_ackCnt;

    logic [2:0] w_stateNext;
    logic       w_respond;
    logic [7:0] w_respByte;
    logic       w_fire;
    logic       w_doWrite;
    logic       w_ovSet;
    logic       w_collecting;
    logic       w_timeout;
    logic       w_rxAddrOk;
    logic       w_latAddrOk;
    logic [7:0] w_rdData;

    // Address is valid only when every bit above the register index is zero
    assign w_rxAddrOk   = (rx_data >> c_AW) == 8'd0;
    assign w_latAddrOk  = (r_addr >> c_AW) == 8'd0;
    assign w_rdData     = r_regs[rx_data[c_AW-1:0]];
    assign w_collecting = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    // A byte arriving in the expiry cycle takes priority over the timeout
    assign w_timeout    = w_collecting && !rx_valid && (r_timer == c_TLIM);

    // Next-state and response decode
    always_comb begin
        w_stateNext = r_state;
        w_respond   = 1'b0;
        w_respByte  = r_txData;
        w_fire      = 1'b0;
        w_doWrite   = 1'b0;
        w_ovSet     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == c_CMD_W || rx_data == c_CMD_R) begin
                        w_stateNext = S_GET_ADDR;
                    end else begin
                        w_respond  = 1'b1;
                        w_respByte = c_RSP_ER;
                    end
                end
            end
            S_GET_ADDR: begin
                if (rx_valid) begin
                    if (r_isWrite) begin
                        w_stateNext = S_GET_DATA;
                    end else begin
                        w_respond  = 1'b1;
                        w_respByte = w_rxAddrOk ? w_rdData : c_RSP_ER;
                    end
                end else if (w_timeout) begin
                    w_stateNext = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (rx_valid) begin
                    w_respond  = 1'b1;
                    w_doWrite  = w_latAddrOk;
                    w_respByte = w_latAddrOk ? c_RSP_OK : c_RSP_ER;
                end else if (w_timeout) begin
                    w_stateNext = S_IDLE;
                end
            end
            S_SEND: begin
                w_ovSet = rx_valid;
                if (!tx_busy) begin
                    w_fire      = 1'b1;
                    w_stateNext = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                w_ovSet = rx_valid;
                if (tx_busy || r_ackCnt == c_ACK_LAST) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
        // Start straight away when the transmitter is idle so tx_start
        // follows the final byte by one cycle; otherwise park in SEND.
        if (w_respond) begin
            if (!tx_busy) begin
                w_fire      = 1'b1;
                w_stateNext = S_WAIT_ACK;
            end else begin
                w_stateNext = S_SEND;
            end
        end
    end

    // State, register file, response and housekeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_isWrite <= 1'b0;
            r_addr    <= 8'h00;
            r_txData  <= 8'h00;
            r_txStart <= 1'b0;
            r_overrun <= 1'b0;
            r_timer   <= '0;
            r_ackCnt  <= 2'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_state   <= w_stateNext;
            r_txStart <= w_fire;
            if (w_respond) begin
                r_txData <= w_respByte;
            end
            if (r_state == S_IDLE && rx_valid) begin
                r_isWrite <= (rx_data == c_CMD_W);
            end
            if (r_state == S_GET_ADDR && rx_valid) begin
                r_addr <= rx_data;
            end
            if (w_doWrite) begin
                r_regs[r_addr[c_AW-1:0]] <= rx_data;
            end
            if (w_ovSet) begin
                r_overrun <= 1'b1;
            end
            if (rx_valid || !w_collecting || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TW'(1);
            end
            if (r_state == S_WAIT_ACK) begin
                r_ackCnt <= r_ackCnt + 2'd1;
            end else begin
                r_ackCnt <= 2'd0;
            end
        end
    end

    assign tx_data  = r_txData;
    // Masked so no start request can leave while reset is held
    assign tx_start = r_txStart && !rst;
    assign reg0     = r_regs[0];
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_responder
// Description : Scoreboard testbench for uart_cmd_responder with a simple
//               transmitter busy model and directed command sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_responder;

    localparam int c_TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] reg0;
    logic       overrun;

    logic modelBusy;
    logic forceBusy;
    logic [7:0] expQ[$];
    int nChecks = 0;
    int nFails  = 0;

    assign tx_busy = modelBusy | forceBusy;

    uart_cmd_responder #(.NUM_REGS(8), .TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
        .reg0(reg0), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for 10 cycles starting one cycle after tx_start
    initial begin
        modelBusy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_start === 1'b1) begin
                modelBusy = 1'b1;
                repeat (10) @(posedge clk);
                #1 modelBusy = 1'b0;
            end
        end
    end

    // Monitor: every tx_start must match the next queued response
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_tx: got 0x%0h, expected no response", tx_data);
                end else begin
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, expQ.pop_front()});
                end
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((expQ.size() != 0 || tx_busy) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 300) begin
            nChecks++;
            nFails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
        end
        idle(6);
    endtask

    initial begin
        int badStarts;
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; forceBusy = 1'b0;
        idle(3);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_reg0", {24'd0, reg0}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Write then read back the same register
        expQ.push_back(8'h4B);
        sendByte(8'h57); sendByte(8'h03); sendByte(8'hA5);
        drain();
        expQ.push_back(8'hA5);
        sendByte(8'h52); sendByte(8'h03);
        drain();

        // reg0 write timing and one-cycle response latency
        expQ.push_back(8'h4B);
        sendByte(8'h57); sendByte(8'h00);
        rx_data = 8'h5C; rx_valid = 1'b1;
        chk("reg0_before", {24'd0, reg0}, 32'h00);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("reg0_after", {24'd0, reg0}, 32'h5C);
        chk("start_latency", {31'd0, tx_start}, 32'd1);
        drain();

        // Error responses
        expQ.push_back(8'h3F);
        sendByte(8'h58);
        drain();
        expQ.push_back(8'h3F);
        sendByte(8'h52); sendByte(8'h09);
        drain();
        expQ.push_back(8'h3F);
        sendByte(8'h57); sendByte(8'h10); sendByte(8'h11);
        drain();
        chk("bad_addr_no_write", {24'd0, reg0}, 32'h5C);
        expQ.push_back(8'h5C);
        sendByte(8'h52); sendByte(8'h00);
        drain();

        // Timeout abandons a half-received write
        sendByte(8'h57); sendByte(8'h01);
        idle(c_TIMEOUT + 1);
        expQ.push_back(8'h00);
        sendByte(8'h52); sendByte(8'h01);
        drain();

        // A gap well inside the timeout is tolerated
        expQ.push_back(8'h4B);
        sendByte(8'h57); sendByte(8'h02);
        idle(c_TIMEOUT / 2);
        sendByte(8'h77);
        drain();
        expQ.push_back(8'h77);
        sendByte(8'h52); sendByte(8'h02);
        drain();

        // Transmitter busy: start held off, then pulses once
        forceBusy = 1'b1;
        expQ.push_back(8'hA5);
        sendByte(8'h52); sendByte(8'h03);
        badStarts = 0;
        repeat (50) begin
            if (tx_start === 1'b1) badStarts++;
            idle(1);
        end
        chk("no_start_while_busy", badStarts, 0);
        forceBusy = 1'b0;
        idle(1);
        chk("start_after_busy", {31'd0, tx_start}, 32'd1);
        idle(1);
        chk("start_single", {31'd0, tx_start}, 32'd0);
        drain();

        // Byte during WAIT_ACK is dropped and flags overrun
        chk("overrun_clear", {31'd0, overrun}, 32'd0);
        expQ.push_back(8'hA5);
        sendByte(8'h52); sendByte(8'h03);
        sendByte(8'h58);
        drain();
        chk("overrun_set", {31'd0, overrun}, 32'd1);

        // Reset in the middle of GET_DATA
        sendByte(8'h57); sendByte(8'h04);
        rst = 1'b1;
        idle(1);
        chk("rst_no_start", {31'd0, tx_start}, 32'd0);
        rst = 1'b0;
        chk("rst_overrun_cleared", {31'd0, overrun}, 32'd0);
        chk("rst_reg0_cleared", {24'd0, reg0}, 32'd0);
        idle(2);
        expQ.push_back(8'h3F);
        sendByte(8'h99);
        drain();
        expQ.push_back(8'h00);
        sendByte(8'h52); sendByte(8'h03);
        drain();

        chk("queue_empty", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
